// File: rtl/fp_stream_accumulator.sv
// Streaming FP32 summation controller wrapped around an external combinational adder.
// Registers operands into the adder and captures its sum/overflow one cycle later.
module fp_stream_accumulator #(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COUNT_W-1:0] len,
    input  logic               in_valid,
    input  logic [31:0]        in_data,
    output logic               in_ready,
    output logic [31:0]        add_a,
    output logic [31:0]        add_b,
    input  logic [31:0]        add_sum,
    input  logic               add_ovf,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_data,
    output logic               out_overflow,
    output logic [COUNT_W-1:0] out_count,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ADD,
        DONE
    } state_t;

    state_t             state;
    state_t             stateNext;
    logic [COUNT_W-1:0] lenReg;
    logic [COUNT_W-1:0] cnt;
    logic [COUNT_W-1:0] cntInc;
    logic [31:0]        acc;
    logic [31:0]        opReg;
    logic               ovfSticky;
    logic               accept;
    logic               firstElem;

    assign cntInc    = cnt + COUNT_W'(1);
    assign accept    = in_valid && in_ready;
    assign firstElem = (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    stateNext = (len == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    if (firstElem) begin
                        stateNext = (lenReg == COUNT_W'(1)) ? DONE : LOAD;
                    end else begin
                        stateNext = ADD;
                    end
                end
            end
            ADD: begin
                stateNext = (cntInc == lenReg) ? DONE : LOAD;
            end
            DONE: begin
                if (out_ready) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // First element bypasses the adder; its overflow comes from an all-ones exponent.
    always_ff @(posedge clk) begin
        if (rst) begin
            lenReg    <= '0;
            cnt       <= '0;
            acc       <= '0;
            opReg     <= '0;
            ovfSticky <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        lenReg    <= len;
                        cnt       <= '0;
                        acc       <= '0;
                        opReg     <= '0;
                        ovfSticky <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (firstElem) begin
                            acc       <= in_data;
                            cnt       <= COUNT_W'(1);
                            ovfSticky <= &in_data[30:23];
                        end else begin
                            opReg <= in_data;
                        end
                    end
                end
                ADD: begin
                    acc       <= add_sum;
                    ovfSticky <= ovfSticky | add_ovf;
                    cnt       <= cntInc;
                end
                default: ;
            endcase
        end
    end

    assign in_ready     = (state == LOAD);
    assign out_valid    = (state == DONE);
    assign busy         = (state != IDLE);
    assign add_a        = acc;
    assign add_b        = opReg;
    assign out_data     = acc;
    assign out_overflow = ovfSticky;
    assign out_count    = cnt;

endmodule

// File: doc/fp_stream_accumulator.md
# fp_stream_accumulator

Sequential controller that sums a stream of IEEE-754 single-precision operands by driving the team's combinational floating-point adder and registering its result. It sits directly around the adder: it feeds operands `A`/`B` from a registered accumulator and operand register, then captures `Sum`/`overFlow` one cycle later. It delivers the final total with valid/ready handshakes on both sides.

## Interface
- `COUNT_W`, 8, width of the element-count field; max stream length 2^COUNT_W − 1
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: pulse to begin a stream; sampled only in IDLE
- `len` in COUNT_W: number of elements to sum; sampled with `start`
- `in_valid` in 1: input operand valid
- `in_data` in 32: input operand, IEEE-754 single
- `in_ready` out 1: accumulator accepts `in_data` this cycle
- `add_a` out 32: to adder `A`; registered accumulator value
- `add_b` out 32: to adder `B`; registered operand value
- `add_sum` in 32: from adder `Sum`
- `add_ovf` in 1: from adder `overFlow`
- `out_valid` out 1: final result valid
- `out_ready` in 1: consumer accepts result
- `out_data` out 32: final sum
- `out_overflow` out 1: sticky overflow flag for the stream
- `out_count` out COUNT_W: elements actually summed
- `busy` out 1: high in any state except IDLE

## Operation
- FSM states: IDLE, LOAD, ADD, DONE. Reset forces IDLE.
- IDLE:
  - `start`=1 and `len`≠0 → latch `len`, clear `cnt`, `acc`, `op_reg` and `ovf_sticky`, then go to LOAD.
  - `start`=1 and `len`=0 → `acc`=0, `ovf`=0, `cnt`=0, then go to DONE.
  - `start` is ignored in every other state.
- LOAD: `in_ready`=1 (combinational from state only). On `in_valid`&&`in_ready`:
  - First element (`cnt`=0): bypass the adder. `acc`←`in_data`, `cnt`←1, `ovf_sticky`←(`in_data[30:23]`==8'hFF). Next state is DONE if `len`=1, else LOAD.
  - Later elements: `op_reg`←`in_data`, then go to ADD.
- ADD: `in_ready`=0. `acc`←`add_sum`, `ovf_sticky`←`ovf_sticky` | `add_ovf`, `cnt`←`cnt`+1. Next state is DONE if `cnt`+1==`len`, else LOAD.
- DONE:
  - `out_valid`=1; `out_data`=`acc`, `out_overflow`=`ovf_sticky`, `out_count`=`cnt`. These are held stable while `out_valid`=1 and `out_ready`=0.
  - `out_ready`=1 → go to IDLE; `out_valid` drops the next cycle.
- `add_a`=`acc` and `add_b`=`op_reg` are direct register outputs. The adder path is purely combinational, from register through the adder to `acc`, within one cycle.
- The data path does no sign, NaN or denormal handling beyond what the adder does. Overflow does not abort the stream; remaining elements are still consumed.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_data`=0, `out_overflow`=0, `out_count`=0, `busy`=0, `add_a`=0, `add_b`=0.
- `start` to LOAD: 1 cycle. `in_ready` first rises in the cycle after `start`.
- Throughput:
  - The first element takes 1 cycle.
  - Each later element takes 2 cycles (LOAD accept, then ADD capture), with `in_ready` low during ADD.
- Latency: `out_valid` rises 1 cycle after the final ADD, or after the LOAD accept when `len`=1.
- `len`=0: `out_valid` rises 1 cycle after `start`, with `out_data`=0 and `out_count`=0.
- `in_valid` low in LOAD: the FSM waits indefinitely with no state change.
- `rst` mid-stream: IDLE on the next edge and all outputs return to reset values. Partial sums are discarded, and an input offered in the same cycle as `rst` is not accepted.
- `start` in the same cycle as a DONE handshake: ignored, because `start` is only sampled in IDLE.
- `cnt` never wraps, since `len` ≤ 2^COUNT_W − 1.

## Test plan
- `len`=3, inputs 0x3F800000, 0x40000000, 0x40400000 (1.0, 2.0, 3.0), `in_valid` always high, `out_ready`=1 → `out_data`=0x40C00000 (6.0), `out_overflow`=0, `out_count`=3, `out_valid` exactly 6 cycles after `start`.
- `len`=1, input 0xC0490FDB (−π) → `out_data`=0xC0490FDB and `add_sum` is unused; `out_valid` 2 cycles after `start`.
- `len`=0 → `out_valid` 1 cycle after `start`, `out_data`=0, `out_count`=0, and `in_ready` never asserts.
- `len`=2, inputs 0x7F000000 and 0x7F000000, where the adder flags overflow → `out_overflow`=1. A second run with a first input of 0x7F800000 also gives `out_overflow`=1.
- Back-pressure: `len`=2, `in_valid` toggled 1-0-0-1 and `out_ready` held low for 4 cycles:
  - `in_ready` is low during ADD.
  - The result is held stable while `out_ready` is low.
  - `busy` stays high until the handshake.
- `rst` asserted after the 2nd element of `len`=4 → next cycle IDLE with `busy`=0 and `out_valid`=0. A fresh `len`=1 stream then returns its own input unchanged.
